audio_sample_fifo: RTL and testbench

Parametrised synchronous FIFO that buffers PCM microphone samples between the capture front-end and downstream consumers (UART/PWM playback/processing).
- Uses single-cycle level-sensitive strobes (no edge detection); full depth 2**ABITS is usable.
- Handles simultaneous read/write correctly.
- Provides fill level, programmable almost-full/almost-empty thresholds, sticky overflow/underflow flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) mode.

---
 rtl/audio_sample_fifo_if.sv | 46 ++++
 rtl/audio_sample_fifo.sv | 135 +++++++++++++
 tb/tb_audio_sample_fifo.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/audio_sample_fifo_if.sv
// ---------------------------------------------------------------------------
// audio_sample_fifo_if
//   Handshake and status bundle for audio_sample_fifo.
//   Signals:
//     clear        flush strobe            (master -> fifo)
//     wr, din      write strobe + data     (master -> fifo)
//     rd           read / pop strobe       (master -> fifo)
//     dout         read data               (fifo -> master)
//     dout_valid   read data qualifier     (fifo -> master)
//     empty, full, almost_empty, almost_full, level
//                  fill status             (fifo -> master)
//     overflow, underflow
//                  sticky error flags      (fifo -> master)
// ---------------------------------------------------------------------------
interface audio_sample_fifo_if #(
  parameter int ABITS = 4,
  parameter int DBITS = 16
);
  logic             clear;
  logic             wr;
  logic [DBITS-1:0] din;
  logic             rd;
  logic [DBITS-1:0] dout;
  logic             dout_valid;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [ABITS:0]   level;
  logic             overflow;
  logic             underflow;

  // Producer / consumer side.
  modport master (
    output clear, wr, din, rd,
    input  dout, dout_valid, empty, full, almost_empty, almost_full,
           level, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  clear, wr, din, rd,
    output dout, dout_valid, empty, full, almost_empty, almost_full,
           level, overflow, underflow
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// ---------------------------------------------------------------------------
// audio_sample_fifo
//   Synchronous FIFO buffering PCM microphone samples between the capture
//   front-end and downstream consumers. All 2**ABITS slots are usable; the
//   fill level alone decides full/empty, so pointers wrap freely.
//   Ports:
//     clock   system clock, rising edge
//     reset   asynchronous, active-high reset
//     bus     audio_sample_fifo_if.slave (strobes, data, status)
//   Parameters:
//     ABITS / DBITS        address / data width
//     AF_LEVEL / AE_LEVEL  almost_full (>=) / almost_empty (<=) thresholds
//     FWFT                 0: registered read, 1: first-word-fall-through
// ---------------------------------------------------------------------------
module audio_sample_fifo #(
  parameter int ABITS    = 4,
  parameter int DBITS    = 16,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input logic                clock,
  input logic                reset,
  audio_sample_fifo_if.slave bus
);

  localparam int             DEPTH   = 2 ** ABITS;
  localparam logic [ABITS:0] DEPTH_L = (ABITS + 1)'(DEPTH);
  localparam logic [ABITS:0] AF_L    = (ABITS + 1)'(AF_LEVEL);
  localparam logic [ABITS:0] AE_L    = (ABITS + 1)'(AE_LEVEL);

  logic [DBITS-1:0] r_mem [DEPTH];
  logic [ABITS-1:0] r_wr_ptr;
  logic [ABITS-1:0] r_rd_ptr;
  logic [ABITS:0]   r_level;
  logic [DBITS-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overflow;
  logic             r_underflow;

  logic w_empty;
  logic w_full;
  logic w_rd_ok;
  logic w_wr_ok;

  // Status is decoded straight from the registered level, so flags move on
  // the same edge as the level itself.
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == DEPTH_L);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // write that is paired with an accepted read.
  assign w_rd_ok = bus.rd & ~w_empty;
  assign w_wr_ok = bus.wr & (~w_full | w_rd_ok);

  // NOTE: the storage array is deliberately left out of reset; level and
  // pointers define which words are live, and an unreset array maps to RAM.
  always_ff @(posedge clock) begin
    if (w_wr_ok && !bus.clear) begin
      r_mem[r_wr_ptr] <= bus.din;
    end
  end

  // NOTE: all state below uses non-blocking assignments so that the memory
  // read of r_mem[r_rd_ptr] sees the pre-edge contents even when a write to
  // the same slot happens on this edge (full FIFO with rd & wr together).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (bus.clear) begin
      // Flush wins over any strobe in the same cycle; dout keeps its value.
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + ABITS'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + ABITS'(1);
      end

      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_level <= r_level + (ABITS + 1)'(1);
        2'b01:   r_level <= r_level - (ABITS + 1)'(1);
        default: r_level <= r_level;
      endcase

      if (bus.wr && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      if (bus.rd && !w_rd_ok) begin
        r_underflow <= 1'b1;
      end

      // Registered read path; only meaningful in standard mode.
      if (FWFT == 0) begin
        r_dout_valid <= w_rd_ok;
        if (w_rd_ok) begin
          r_dout <= r_mem[r_rd_ptr];
        end
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; forced to zero while empty
      // so reset and empty both show a defined value.
      assign bus.dout       = w_empty ? '0 : r_mem[r_rd_ptr];
      assign bus.dout_valid = ~w_empty;
    end else begin : g_std
      assign bus.dout       = r_dout;
      assign bus.dout_valid = r_dout_valid;
    end
  endgenerate

  assign bus.empty        = w_empty;
  assign bus.full         = w_full;
  assign bus.almost_empty = (r_level <= AE_L);
  assign bus.almost_full  = (r_level >= AF_L);
  assign bus.level        = r_level;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// ---------------------------------------------------------------------------
// tb_audio_sample_fifo
//   Directed bench for audio_sample_fifo. Two instances share clock/reset:
//   u_std (FWFT=0) and u_fwft (FWFT=1), both ABITS=2, DBITS=16,
//   AF_LEVEL=3, AE_LEVEL=1. Inputs change 1 time unit after the rising edge
//   and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_audio_sample_fifo;

  logic clock;
  logic reset;

  int n_checks = 0;
  int n_pass   = 0;

  audio_sample_fifo_if #(.ABITS(2), .DBITS(16)) bus0 ();
  audio_sample_fifo_if #(.ABITS(2), .DBITS(16)) bus1 ();

  audio_sample_fifo #(
    .ABITS(2), .DBITS(16), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)
  ) u_std (
    .clock (clock),
    .reset (reset),
    .bus   (bus0.slave)
  );

  audio_sample_fifo #(
    .ABITS(2), .DBITS(16), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)
  ) u_fwft (
    .clock (clock),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_std(input string tag);
    check({tag, " level"},        32'(bus0.level),   32'd0);
    check({tag, " empty"},        32'(bus0.empty),   32'd1);
    check({tag, " full"},         32'(bus0.full),    32'd0);
    check({tag, " almost_empty"}, 32'(bus0.almost_empty), 32'd1);
    check({tag, " almost_full"},  32'(bus0.almost_full),  32'd0);
    check({tag, " dout"},         32'(bus0.dout),    32'd0);
    check({tag, " dout_valid"},   32'(bus0.dout_valid), 32'd0);
    check({tag, " overflow"},     32'(bus0.overflow),   32'd0);
    check({tag, " underflow"},    32'(bus0.underflow),  32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    bus0.clear = 1'b0; bus0.wr = 1'b0; bus0.rd = 1'b0; bus0.din = '0;
    bus1.clear = 1'b0; bus1.wr = 1'b0; bus1.rd = 1'b0; bus1.din = '0;

    // Reset state.
    #1;
    check_reset_std("rst");
    check("rst fwft dout_valid", 32'(bus1.dout_valid), 32'd0);
    check("rst fwft empty",      32'(bus1.empty),      32'd1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // 1. Fill to full.
    bus0.wr = 1'b1; bus0.din = 16'h1111; tick();
    check("t1 level1", 32'(bus0.level), 32'd1);
    check("t1 ae@1",   32'(bus0.almost_empty), 32'd1);
    check("t1 empty@1", 32'(bus0.empty), 32'd0);
    bus0.din = 16'h2222; tick();
    check("t1 level2", 32'(bus0.level), 32'd2);
    check("t1 ae@2",   32'(bus0.almost_empty), 32'd0);
    check("t1 af@2",   32'(bus0.almost_full),  32'd0);
    bus0.din = 16'h3333; tick();
    check("t1 level3", 32'(bus0.level), 32'd3);
    check("t1 af@3",   32'(bus0.almost_full), 32'd1);
    check("t1 full@3", 32'(bus0.full), 32'd0);
    bus0.din = 16'h4444; tick();
    check("t1 level4", 32'(bus0.level), 32'd4);
    check("t1 full@4", 32'(bus0.full), 32'd1);
    check("t1 ovf",    32'(bus0.overflow), 32'd0);

    // 2. Rejected write, then simultaneous rd/wr while full.
    bus0.din = 16'h5555; tick();
    check("t2 ovf set",   32'(bus0.overflow), 32'd1);
    check("t2 level4",    32'(bus0.level), 32'd4);
    bus0.rd = 1'b1; bus0.din = 16'h6666; tick();
    check("t2 dout",      32'(bus0.dout), 32'h1111);
    check("t2 dv",        32'(bus0.dout_valid), 32'd1);
    check("t2 level",     32'(bus0.level), 32'd4);
    check("t2 full",      32'(bus0.full), 32'd1);
    bus0.rd = 1'b0; bus0.wr = 1'b0; tick();
    check("t2 dv pulse",  32'(bus0.dout_valid), 32'd0);
    check("t2 dout hold", 32'(bus0.dout), 32'h1111);

    // 3. Drain and read past empty.
    bus0.rd = 1'b1; tick();
    check("t3 rd0", 32'(bus0.dout), 32'h2222);
    check("t3 lv3", 32'(bus0.level), 32'd3);
    tick();
    check("t3 rd1", 32'(bus0.dout), 32'h3333);
    tick();
    check("t3 rd2", 32'(bus0.dout), 32'h4444);
    check("t3 dv2", 32'(bus0.dout_valid), 32'd1);
    tick();
    check("t3 rd3",   32'(bus0.dout), 32'h6666);
    check("t3 lv0",   32'(bus0.level), 32'd0);
    check("t3 empty", 32'(bus0.empty), 32'd1);
    check("t3 unf0",  32'(bus0.underflow), 32'd0);
    tick();
    check("t3 unf",       32'(bus0.underflow), 32'd1);
    check("t3 dout hold", 32'(bus0.dout), 32'h6666);
    check("t3 no dv",     32'(bus0.dout_valid), 32'd0);
    bus0.rd = 1'b0;

    // 4. Wrap: streaming write/read pairs, level held at 1.
    bus0.wr = 1'b1; bus0.din = 16'd0; tick();
    check("t4 lv first", 32'(bus0.level), 32'd1);
    bus0.rd = 1'b1;
    for (int i = 1; i < 10; i++) begin
      bus0.din = 16'(i); tick();
      check($sformatf("t4 dout%0d", i - 1), 32'(bus0.dout), 32'(i - 1));
      check($sformatf("t4 lv%0d", i - 1),   32'(bus0.level), 32'd1);
    end
    bus0.wr = 1'b0; tick();
    check("t4 dout9", 32'(bus0.dout), 32'd9);
    check("t4 lv end", 32'(bus0.level), 32'd0);
    bus0.rd = 1'b0;

    // Flush clears sticky flags, then rd & wr on an empty FIFO.
    bus0.clear = 1'b1; tick(); bus0.clear = 1'b0;
    check("clr unf", 32'(bus0.underflow), 32'd0);
    check("clr dv",  32'(bus0.dout_valid), 32'd0);
    check("clr dout hold", 32'(bus0.dout), 32'd9);
    bus0.rd = 1'b1; bus0.wr = 1'b1; bus0.din = 16'h7777; tick();
    check("erw level", 32'(bus0.level), 32'd1);
    check("erw unf",   32'(bus0.underflow), 32'd1);
    check("erw dv",    32'(bus0.dout_valid), 32'd0);
    bus0.wr = 1'b0; tick();
    check("erw dout",  32'(bus0.dout), 32'h7777);
    check("erw dv1",   32'(bus0.dout_valid), 32'd1);
    bus0.rd = 1'b0;

    // 5. FWFT instance.
    bus1.wr = 1'b1; bus1.din = 16'hABCD; tick(); bus1.wr = 1'b0;
    check("t5 dout",  32'(bus1.dout), 32'hABCD);
    check("t5 dv",    32'(bus1.dout_valid), 32'd1);
    check("t5 empty", 32'(bus1.empty), 32'd0);
    bus1.rd = 1'b1; tick(); bus1.rd = 1'b0;
    check("t5 empty after rd", 32'(bus1.empty), 32'd1);
    check("t5 dv after rd",    32'(bus1.dout_valid), 32'd0);
    bus1.wr = 1'b1; bus1.din = 16'h1234; tick();
    bus1.din = 16'h5678; tick(); bus1.wr = 1'b0;
    check("t5 head",   32'(bus1.dout), 32'h1234);
    check("t5 level2", 32'(bus1.level), 32'd2);
    bus1.rd = 1'b1; tick();
    check("t5 next",   32'(bus1.dout), 32'h5678);
    check("t5 dv next", 32'(bus1.dout_valid), 32'd1);
    tick(); bus1.rd = 1'b0;
    check("t5 drained", 32'(bus1.dout_valid), 32'd0);
    check("t5 unf0",    32'(bus1.underflow), 32'd0);

    // 6. Level 3 with overflow set, then clear + wr, then async reset.
    bus0.wr = 1'b1;
    bus0.din = 16'hA001; tick();
    bus0.din = 16'hA002; tick();
    bus0.din = 16'hA003; tick();
    bus0.din = 16'hA004; tick();
    bus0.din = 16'hA005; tick();
    check("t6 ovf", 32'(bus0.overflow), 32'd1);
    bus0.wr = 1'b0; bus0.rd = 1'b1; tick(); bus0.rd = 1'b0;
    check("t6 level3", 32'(bus0.level), 32'd3);
    check("t6 dout",   32'(bus0.dout), 32'hA001);
    bus0.clear = 1'b1; bus0.wr = 1'b1; bus0.din = 16'hBEEF; tick();
    bus0.clear = 1'b0; bus0.wr = 1'b0;
    check("t6 clr level", 32'(bus0.level), 32'd0);
    check("t6 clr empty", 32'(bus0.empty), 32'd1);
    check("t6 clr ovf",   32'(bus0.overflow), 32'd0);
    check("t6 clr unf",   32'(bus0.underflow), 32'd0);
    check("t6 clr dv",    32'(bus0.dout_valid), 32'd0);
    check("t6 clr dout",  32'(bus0.dout), 32'hA001);
    bus0.wr = 1'b1; bus0.din = 16'hC001; tick();
    bus0.din = 16'hC002; tick();
    check("t6 refill", 32'(bus0.level), 32'd2);
    bus1.wr = 1'b1; bus1.din = 16'hD001; tick(); bus1.wr = 1'b0;
    check("t6 fwft lv", 32'(bus1.level), 32'd1);
    bus0.din = 16'hC003;
    bus0.rd  = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_reset_std("t6 async");
    check("t6 async fwft empty", 32'(bus1.empty), 32'd1);
    check("t6 async fwft dv",    32'(bus1.dout_valid), 32'd0);
    check("t6 async fwft lv",    32'(bus1.level), 32'd0);
    bus0.wr = 1'b0; bus0.rd = 1'b0;
    tick();
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
